// File: rtl/parity_check_rx.sv
// Serial frame receiver: N data bits (LSB first) plus one parity bit, with
// a registered result strobe, a parity error flag and a saturating error counter.
module parity_check_rx #(
   parameter int N   = 8,
   parameter int ODD = 0,
   parameter int CW  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         bit_in,
   input  logic         bit_valid,
   input  logic         clr_cnt,
   output logic [N-1:0] data_out,
   output logic         out_valid,
   output logic         par_err,
   output logic         busy,
   output logic         abort,
   output logic [CW-1:0] err_cnt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam int          KW    = $clog2(N + 1);
   localparam logic [KW-1:0] LAST = KW'(N - 1);
   localparam logic        SENSE = (ODD != 0);

   logic [1:0]    state;
   logic [N-1:0]  shift;
   logic [KW-1:0] cnt;
   logic [N-1:0]  bit_mask;

   // Shift register is cleared on every start, so each accepted bit only ORs in.
   assign bit_mask = {{(N-1){1'b0}}, bit_in} << cnt;
   assign busy     = (state == DATA) || (state == PARITY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift     <= '0;
         cnt       <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         par_err   <= 1'b0;
         abort     <= 1'b0;
         err_cnt   <= '0;
      end else begin
         out_valid <= 1'b0;
         abort     <= 1'b0;

         if (clr_cnt)
            err_cnt <= '0;
         else if (state == DONE && par_err && err_cnt != {CW{1'b1}})
            err_cnt <= err_cnt + CW'(1);

         case (state)
            IDLE: begin
               if (start) begin
                  state <= DATA;
                  cnt   <= '0;
                  shift <= '0;
               end
            end
            DATA: begin
               if (start) begin
                  abort <= 1'b1;
                  cnt   <= '0;
                  shift <= '0;
               end else if (bit_valid) begin
                  shift <= shift | bit_mask;
                  cnt   <= cnt + KW'(1);
                  if (cnt == LAST)
                     state <= PARITY;
               end
            end
            PARITY: begin
               if (start) begin
                  abort <= 1'b1;
                  state <= DATA;
                  cnt   <= '0;
                  shift <= '0;
               end else if (bit_valid) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  data_out  <= shift;
                  par_err   <= ((^shift) ^ bit_in) != SENSE;
               end
            end
            default: begin
               // DONE lasts one cycle; a start here chains straight into the next frame.
               if (start) begin
                  state <= DATA;
                  cnt   <= '0;
                  shift <= '0;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
